// File: rtl/pro2003.sv
// Pushbutton press counter (two BCD digits) with a continuously refreshed LCD1602 readout.
// Optional long-press clear is compiled in when PRO2003_LONG_CLEAR_EN is defined.
module pro2003 #(
    parameter int DEBOUNCE_CYC = 1_000_000,
    parameter int LCD_CYC      = 50_000,
    parameter int PWR_WAIT     = 1_000_000,
    parameter int CLR_WAIT     = 100_000
`ifdef PRO2003_LONG_CLEAR_EN
    , parameter int LONG_CYC   = 100_000_000
`endif
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       key_sigle,
    output logic       key_pressed,
    output logic [7:0] key_cnt,
    output logic       lcd_rs,
    output logic       lcd_rw,
    output logic       lcd_en,
    output logic [7:0] lcd_data
);
    localparam int DB_W    = $clog2(DEBOUNCE_CYC + 1);
    localparam int TMR_MAX = (PWR_WAIT > LCD_CYC) ?
                             ((PWR_WAIT > CLR_WAIT) ? PWR_WAIT : CLR_WAIT) :
                             ((LCD_CYC > CLR_WAIT) ? LCD_CYC : CLR_WAIT);
    localparam int TMR_W   = $clog2(TMR_MAX + 1);

    localparam logic [DB_W-1:0]  DB_LAST   = DB_W'(DEBOUNCE_CYC - 1);
    localparam logic [TMR_W-1:0] PWR_LAST  = TMR_W'(PWR_WAIT - 1);
    localparam logic [TMR_W-1:0] SLOT_LAST = TMR_W'(LCD_CYC - 1);
    localparam logic [TMR_W-1:0] CLR_LAST  = TMR_W'(CLR_WAIT - 1);
    localparam logic [TMR_W-1:0] EN_LAST   = TMR_W'(LCD_CYC / 2);
    localparam logic [2:0]       INIT_LAST = 3'd3;
    localparam logic [2:0]       FRM_LAST  = 3'd6;

    typedef enum logic [1:0] {S_PWR, S_INIT, S_CLRW, S_REFRESH} state_t;

    function automatic logic [7:0] bcd_inc(input logic [7:0] v);
        logic [3:0] t;
        logic [3:0] u;
        t = v[7:4];
        u = v[3:0];
        if (u == 4'd9) begin
            u = 4'd0;
            t = (t == 4'd9) ? 4'd0 : t + 4'd1;
        end else begin
            u = u + 4'd1;
        end
        return {t, u};
    endfunction

    logic            r_sync1, r_sync2, r_stable, r_stable_d;
    logic [DB_W-1:0] r_db_cnt;
    logic            r_key_pressed;
    logic [7:0]      r_key_cnt;
    logic            w_press;
    logic            w_long_clr;

    // Key path: synchronizer, then debounce against the stable level
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_sync1    <= 1'b1;
            r_sync2    <= 1'b1;
            r_stable   <= 1'b1;
            r_stable_d <= 1'b1;
            r_db_cnt   <= '0;
        end else begin
            r_sync1    <= key_sigle;
            r_sync2    <= r_sync1;
            r_stable_d <= r_stable;
            if (r_sync2 == r_stable) begin
                r_db_cnt <= '0;
            end else if (r_db_cnt == DB_LAST) begin
                r_stable <= r_sync2;
                r_db_cnt <= '0;
            end else begin
                r_db_cnt <= r_db_cnt + 1'b1;
            end
        end
    end

    assign w_press = r_stable_d & ~r_stable;

`ifdef PRO2003_LONG_CLEAR_EN
    localparam int HOLD_W = $clog2(LONG_CYC + 1);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(LONG_CYC - 1);
    localparam logic [HOLD_W-1:0] HOLD_MAX  = HOLD_W'(LONG_CYC);

    logic [HOLD_W-1:0] r_hold;

    // Hold counter saturates so the clear fires only once per hold
    always_ff @(posedge clk) begin
        if (!rst_n || r_stable) begin
            r_hold <= '0;
        end else if (r_hold != HOLD_MAX) begin
            r_hold <= r_hold + 1'b1;
        end
    end

    assign w_long_clr = !r_stable && (r_hold == HOLD_LAST);
`else
    assign w_long_clr = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_key_pressed <= 1'b0;
            r_key_cnt     <= 8'h00;
        end else begin
            r_key_pressed <= w_press;
            if (w_long_clr) begin
                r_key_cnt <= 8'h00;
            end else if (w_press) begin
                r_key_cnt <= bcd_inc(r_key_cnt);
            end
        end
    end

    state_t           r_state, w_state_nxt;
    logic [TMR_W-1:0] r_tmr, w_tmr_nxt;
    logic [2:0]       r_idx, w_idx_nxt;
    logic [7:0]       r_snap, w_snap_nxt;
    logic             r_lcd_rs, r_lcd_en;
    logic [7:0]       r_lcd_data;
    logic             w_rs_nxt, w_en_nxt;
    logic [7:0]       w_data_nxt;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state    <= S_PWR;
            r_tmr      <= '0;
            r_idx      <= '0;
            r_snap     <= 8'h00;
            r_lcd_rs   <= 1'b0;
            r_lcd_en   <= 1'b0;
            r_lcd_data <= 8'h00;
        end else begin
            r_state    <= w_state_nxt;
            r_tmr      <= w_tmr_nxt;
            r_idx      <= w_idx_nxt;
            r_snap     <= w_snap_nxt;
            r_lcd_rs   <= w_rs_nxt;
            r_lcd_en   <= w_en_nxt;
            r_lcd_data <= w_data_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_tmr_nxt   = r_tmr + 1'b1;
        w_idx_nxt   = r_idx;
        case (r_state)
            S_PWR: begin
                if (r_tmr == PWR_LAST) begin
                    w_state_nxt = S_INIT;
                    w_tmr_nxt   = '0;
                    w_idx_nxt   = '0;
                end
            end
            S_INIT: begin
                if (r_tmr == SLOT_LAST) begin
                    w_tmr_nxt = '0;
                    if (r_idx == INIT_LAST) w_state_nxt = S_CLRW;
                    else                    w_idx_nxt   = r_idx + 3'd1;
                end
            end
            S_CLRW: begin
                if (r_tmr == CLR_LAST) begin
                    w_state_nxt = S_REFRESH;
                    w_tmr_nxt   = '0;
                    w_idx_nxt   = '0;
                end
            end
            default: begin
                if (r_tmr == SLOT_LAST) begin
                    w_tmr_nxt = '0;
                    w_idx_nxt = (r_idx == FRM_LAST) ? 3'd0 : r_idx + 3'd1;
                end
            end
        endcase
    end

    // Pin values are decoded from the next state so the bus registers line up with slot cycle 0
    always_comb begin
        w_snap_nxt = r_snap;
        w_rs_nxt   = 1'b0;
        w_en_nxt   = 1'b0;
        w_data_nxt = 8'h00;
        if (w_state_nxt == S_REFRESH && w_idx_nxt == 3'd0 && w_tmr_nxt == '0)
            w_snap_nxt = r_key_cnt;
        if (w_state_nxt == S_INIT || w_state_nxt == S_REFRESH)
            w_en_nxt = (w_tmr_nxt != '0) && (w_tmr_nxt <= EN_LAST);
        if (w_state_nxt == S_INIT) begin
            case (w_idx_nxt)
                3'd0:    w_data_nxt = 8'h38;
                3'd1:    w_data_nxt = 8'h0C;
                3'd2:    w_data_nxt = 8'h06;
                default: w_data_nxt = 8'h01;
            endcase
        end else if (w_state_nxt == S_REFRESH) begin
            w_rs_nxt = (w_idx_nxt != 3'd0);
            case (w_idx_nxt)
                3'd0:    w_data_nxt = 8'h80;
                3'd1:    w_data_nxt = 8'h4B;
                3'd2:    w_data_nxt = 8'h45;
                3'd3:    w_data_nxt = 8'h59;
                3'd4:    w_data_nxt = 8'h3A;
                3'd5:    w_data_nxt = 8'h30 + {4'h0, w_snap_nxt[7:4]};
                default: w_data_nxt = 8'h30 + {4'h0, w_snap_nxt[3:0]};
            endcase
        end
    end

    assign key_pressed = r_key_pressed;
    assign key_cnt     = r_key_cnt;
    assign lcd_rs      = r_lcd_rs;
    assign lcd_rw      = 1'b0;
    assign lcd_en      = r_lcd_en;
    assign lcd_data    = r_lcd_data;
endmodule

// File: tb/tb_pro2003.sv
// Bench for pro2003: directed and random key stimulus against an arithmetic press/BCD model,
// plus LCD write-slot capture compared with the expected command/data stream and timing.
module tb_pro2003;
    localparam int DB = 4;
    localparam int LC = 8;
    localparam int PW = 16;
    localparam int CW = 8;
    localparam int LG = 40;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       key_sigle = 1'b1;
    logic       key_pressed;
    logic [7:0] key_cnt;
    logic       lcd_rs, lcd_rw, lcd_en;
    logic [7:0] lcd_data;

    always #5 clk = ~clk;

    pro2003 #(
        .DEBOUNCE_CYC(DB),
        .LCD_CYC(LC),
        .PWR_WAIT(PW),
        .CLR_WAIT(CW)
`ifdef PRO2003_LONG_CLEAR_EN
        , .LONG_CYC(LG)
`endif
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .key_sigle(key_sigle),
        .key_pressed(key_pressed),
        .key_cnt(key_cnt),
        .lcd_rs(lcd_rs),
        .lcd_rw(lcd_rw),
        .lcd_en(lcd_en),
        .lcd_data(lcd_data)
    );

    typedef struct {
        logic        rs;
        logic [7:0]  d;
        int unsigned c;
    } wr_t;

    wr_t         writes[$];
    int          n_assert = 0;
    int          n_fail = 0;
    int unsigned cyc = 0;
    int          pulses = 0;
    logic        prev_en = 1'b0;
    int          hi_cnt = 0;
    logic        held_rs = 1'b0;
    logic [7:0]  held_d = 8'h00;
    int          model_n = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] exp_bcd(input int n);
        int m;
        m = n % 100;
        return 8'((m / 10) * 16 + (m % 10));
    endfunction

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic key_seq(input int lo, input int hi);
        key_sigle = 1'b0;
        tick(lo);
        key_sigle = 1'b1;
        tick(hi);
    endtask

    always @(posedge clk) cyc <= rst_n ? cyc + 1 : 0;

    always @(negedge clk) begin
        if (!rst_n) begin
            prev_en = 1'b0;
            hi_cnt  = 0;
        end else begin
            if (key_pressed) pulses++;
            if (lcd_en && !prev_en) begin
                writes.push_back('{lcd_rs, lcd_data, cyc});
                held_rs = lcd_rs;
                held_d  = lcd_data;
                hi_cnt  = 0;
            end
            if (lcd_en) hi_cnt++;
            if (!lcd_en && prev_en) begin
                chk("en_width", hi_cnt, LC / 2);
                chk("bus_hold", {lcd_rs, lcd_data}, {held_rs, held_d});
            end
            prev_en = lcd_en;
        end
    end

    initial begin
        logic [8:0]  exp_wr[11];
        int unsigned exp_c;
        int          p;
        int          lo, hi, w;

        rst_n = 1'b0;
        key_sigle = 1'b1;
        tick(3);
        chk("rst_pressed", key_pressed, 0);
        chk("rst_cnt", key_cnt, 0);
        chk("rst_rs", lcd_rs, 0);
        chk("rst_rw", lcd_rw, 0);
        chk("rst_en", lcd_en, 0);
        chk("rst_data", lcd_data, 0);
        writes.delete();

        // Key held low for the first 10 cycles after reset release
        rst_n = 1'b1;
        key_sigle = 1'b0;
        tick(10);
        key_sigle = 1'b1;
        tick(170);
        model_n = 1;
        chk("first_pulses", pulses, 1);
        chk("first_cnt", key_cnt, exp_bcd(model_n));

        exp_wr = '{9'h038, 9'h00C, 9'h006, 9'h001, 9'h080, 9'h14B, 9'h145, 9'h159, 9'h13A,
                   9'h130, 9'h130};
        exp_wr[9]  = {1'b1, 8'h30 + 8'((model_n % 100) / 10)};
        exp_wr[10] = {1'b1, 8'h30 + 8'(model_n % 10)};
        chk("nwrites", writes.size() >= 11, 1);
        for (int i = 0; i < 11; i++) begin
            if (i < writes.size()) begin
                exp_c = (i < 4) ? PW + 1 + i * LC : PW + 1 + 4 * LC + CW + (i - 4) * LC;
                chk($sformatf("wr%0d_val", i), {writes[i].rs, writes[i].d}, exp_wr[i]);
                chk($sformatf("wr%0d_cyc", i), writes[i].c, exp_c);
            end
        end

        // Bounce one cycle shorter than the debounce window
        p = pulses;
        key_seq(DB - 1, 12);
        chk("glitch_pulses", pulses - p, 0);
        chk("glitch_cnt", key_cnt, exp_bcd(model_n));

        // Exactly the debounce window
        p = pulses;
        key_seq(DB, 12);
        model_n++;
        chk("exact_pulses", pulses - p, 1);
        chk("exact_cnt", key_cnt, exp_bcd(model_n));

        for (int i = 0; i < 30; i++) begin
            lo = $urandom_range(2 * DB + 3, 1);
            hi = $urandom_range(2 * DB + 6, DB + 3);
            p = pulses;
            key_seq(lo, hi);
            if (lo >= DB) model_n++;
            chk($sformatf("rnd%0d_pulses", i), pulses - p, (lo >= DB) ? 1 : 0);
            chk($sformatf("rnd%0d_cnt", i), key_cnt, exp_bcd(model_n));
        end

        // Reset while a refresh slot has the strobe high
        w = 0;
        while (!lcd_en && w < 100) begin
            tick(1);
            w++;
        end
        chk("wait_en", lcd_en, 1);
        rst_n = 1'b0;
        tick(1);
        chk("midrst_cnt", key_cnt, 0);
        chk("midrst_en", lcd_en, 0);
        chk("midrst_pressed", key_pressed, 0);
        tick(1);
        writes.delete();
        rst_n = 1'b1;
        model_n = 0;
        tick(30);
        chk("restart_nwr", writes.size() >= 2, 1);
        if (writes.size() >= 2) begin
            chk("restart_wr0", {writes[0].rs, writes[0].d}, 9'h038);
            chk("restart_cyc0", writes[0].c, PW + 1);
            chk("restart_wr1", {writes[1].rs, writes[1].d}, 9'h00C);
        end

        p = pulses;
        for (int i = 1; i <= 100; i++) begin
            key_seq(DB + 2, DB + 4);
            model_n++;
            chk($sformatf("clean%0d_cnt", i), key_cnt, exp_bcd(model_n));
            if (i == 10) chk("carry_09_10", key_cnt, 8'h10);
            if (i == 100) chk("wrap_99_00", key_cnt, 8'h00);
        end
        chk("clean_pulses", pulses - p, 100);

        for (int i = 0; i < 5; i++) key_seq(DB + 2, DB + 4);
        model_n += 5;
        chk("pre_hold_cnt", key_cnt, exp_bcd(model_n));
        p = pulses;
        key_sigle = 1'b0;
        tick(20);
        chk("hold_press_cnt", key_cnt, 8'h06);
        tick(40);
        key_sigle = 1'b1;
        tick(12);
`ifdef PRO2003_LONG_CLEAR_EN
        chk("hold_cleared", key_cnt, 8'h00);
`else
        chk("hold_kept", key_cnt, 8'h06);
`endif
        chk("hold_pulses", pulses - p, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
